idma_stream_id_tracker: RTL and testbench

Per-stream transfer-ID issuer and completion tracker, placed directly downstream of the register front-end and upstream of the backend. It forwards accepted requests to the backend and supplies the ID for the launching transfer (`next_id`). An in-order FIFO records which stream each outstanding transfer belongs to. Backend completions are mapped back to their stream, which produces the per-stream `done_id` and busy status that the front-end exposes to software.

---
 rtl/idma_stream_id_tracker_pkg.sv | 19 +
 rtl/idma_stream_id_tracker_fifo.sv | 65 ++++++
 rtl/idma_stream_id_tracker.sv | 131 +++++++++++++
 tb/tb_idma_stream_id_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/idma_stream_id_tracker_pkg.sv
// ============================================================================
// Module   : idma_stream_id_tracker_pkg
// Purpose  : Shared helpers for the per-stream transfer-ID tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package idma_stream_id_tracker_pkg;

  localparam int unsigned MaxStreams = 16;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idma_stream_id_tracker_fifo.sv
// ============================================================================
// Module   : idma_stream_id_tracker_fifo
// Purpose  : Registered-output in-order FIFO with active-low async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_stream_id_tracker_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth  = $clog2(DEPTH + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (cnt_q == CntWidth'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; validity is tracked solely by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrWidth'(1);
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrWidth'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/idma_stream_id_tracker.sv
// ============================================================================
// Module   : idma_stream_id_tracker
// Purpose  : Per-stream transfer-ID issuer and in-order completion tracker.
//            Optional sticky error flag: IDMA_STREAM_ID_TRACKER_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_stream_id_tracker
  import idma_stream_id_tracker_pkg::*;
#(
  parameter int unsigned NumStreams     = 1,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned StreamWidth    = idx_width(NumStreams),
  parameter int unsigned OutCntWidth    = $clog2(MaxOutstanding + 1),
  parameter type         dma_req_t      = logic
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  dma_req_t                             req_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [StreamWidth-1:0]               stream_idx_i,
  output logic [IdCounterWidth-1:0]            next_id_o,
  output dma_req_t                             req_o,
  output logic                                 req_valid_o,
  input  logic                                 req_ready_i,
  input  logic                                 rsp_valid_i,
  output logic                                 rsp_ready_o,
  output logic [NumStreams*IdCounterWidth-1:0] done_id_o,
  output logic [NumStreams-1:0]                busy_o,
  output logic                                 err_o
);

  typedef logic [StreamWidth-1:0]    stream_t;
  typedef logic [IdCounterWidth-1:0] cnt_width_t;
  typedef logic [OutCntWidth-1:0]    out_cnt_t;

  localparam stream_t LastStream = stream_t'(NumStreams - 1);

  cnt_width_t issue_cnt_q [NumStreams];
  cnt_width_t issue_cnt_d [NumStreams];
  cnt_width_t done_id_q   [NumStreams];
  cnt_width_t done_id_d   [NumStreams];
  out_cnt_t   out_cnt_q   [NumStreams];
  out_cnt_t   out_cnt_d   [NumStreams];

  stream_t stream_sel, fifo_head;
  logic    fifo_full, fifo_empty, accept, complete;

  // Out-of-range requests are still forwarded but accounted to the last stream.
  assign stream_sel  = (stream_idx_i > LastStream) ? LastStream : stream_idx_i;

  assign req_o       = req_i;
  assign req_valid_o = req_valid_i & ~fifo_full & ~rst_i;
  assign req_ready_o = req_ready_i & ~fifo_full;
  assign rsp_ready_o = 1'b1;
  assign accept      = req_valid_i & req_ready_o;
  assign complete    = rsp_valid_i & ~fifo_empty;
  assign next_id_o   = issue_cnt_q[stream_sel];

  idma_stream_id_tracker_fifo #(
    .DATA_WIDTH (StreamWidth),
    .DEPTH      (MaxOutstanding)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (stream_sel),
    .pop_i   (complete),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    done_id_d   = done_id_q;
    out_cnt_d   = out_cnt_q;
    if (accept)   issue_cnt_d[stream_sel] = issue_cnt_q[stream_sel] + cnt_width_t'(1);
    if (complete) done_id_d[fifo_head]    = done_id_q[fifo_head] + cnt_width_t'(1);
    for (int k = 0; k < NumStreams; k++) begin
      // A matching issue and retire in one cycle leave the count untouched.
      case ({accept && (stream_sel == stream_t'(k)), complete && (fifo_head == stream_t'(k))})
        2'b10:   out_cnt_d[k] = out_cnt_q[k] + out_cnt_t'(1);
        2'b01:   out_cnt_d[k] = out_cnt_q[k] - out_cnt_t'(1);
        default: out_cnt_d[k] = out_cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumStreams; k++) begin
        issue_cnt_q[k] <= cnt_width_t'(1);
        done_id_q[k]   <= '0;
        out_cnt_q[k]   <= '0;
      end
    end else begin
      issue_cnt_q <= issue_cnt_d;
      done_id_q   <= done_id_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  for (genvar g = 0; g < NumStreams; g++) begin : g_stream
    assign done_id_o[g*IdCounterWidth +: IdCounterWidth] = done_id_q[g];
    assign busy_o[g] = (out_cnt_q[g] != '0);
  end

`ifdef IDMA_STREAM_ID_TRACKER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (rsp_valid_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idma_stream_id_tracker.sv
// ============================================================================
// Module   : tb_idma_stream_id_tracker
// Purpose  : Scoreboard bench for idma_stream_id_tracker (2 streams, 4-bit IDs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idma_stream_id_tracker;

  localparam int NS = 2;
  localparam int W  = 4;
  localparam int MO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_i = 1'b1;
  logic [0:0]    stream_idx_i = 1'b0;
  logic          rsp_valid_i = 1'b0;
  logic          req_ready_o, req_o, req_valid_o, rsp_ready_o, err_o;
  logic [W-1:0]  next_id_o;
  logic [NS*W-1:0] done_id_o;
  logic [NS-1:0] busy_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic       exp_err;

  idma_stream_id_tracker #(
    .NumStreams     (NS),
    .IdCounterWidth (W),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .stream_idx_i (stream_idx_i),
    .next_id_o    (next_id_o),
    .req_o        (req_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .done_id_o    (done_id_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] done_of(input int k);
    return 32'(done_id_o[k*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; its expected ID goes to the scoreboard.
  task automatic issue(input logic st, input logic [W-1:0] id, input logic rsp);
    req_valid_i  = 1'b1;
    stream_idx_i = st;
    req_i        = id[0];
    rsp_valid_i  = rsp;
    exp_q.push_back(id);
    tick();
    req_valid_i  = 1'b0;
    rsp_valid_i  = 1'b0;
  endtask

  task automatic pulse_rsp();
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
  endtask

  // Monitor: every accepted request is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && req_valid_i && req_ready_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got next_id %0d expected no accept", next_id_o);
      end else begin
        check("next_id", 32'(next_id_o), 32'(exp_q.pop_front()));
        check("req_valid_o_on_accept", 32'(req_valid_o), 32'd1);
        check("req_o_passthrough", 32'(req_o), 32'(req_i));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef IDMA_STREAM_ID_TRACKER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset values, with a request pending to show the valid gating.
    req_valid_i = 1'b1;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done0", done_of(0), 32'd0);
    check("rst_done1", done_of(1), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_next_id", 32'(next_id_o), 32'd1);
    check("rst_req_valid_o", 32'(req_valid_o), 32'd0);
    check("rst_req_ready_o", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single transfer on stream 0.
    issue(1'b0, 4'd1, 1'b0);
    check("t1_busy", 32'(busy_o), 32'd1);
    pulse_rsp();
    check("t1_done0", done_of(0), 32'd1);
    check("t1_busy_clr", 32'(busy_o), 32'd0);

    // Interleaved streams 0,1,0 then three in-order completions.
    issue(1'b0, 4'd2, 1'b0);
    issue(1'b1, 4'd1, 1'b0);
    issue(1'b0, 4'd3, 1'b0);
    check("t2_busy_all", 32'(busy_o), 32'd3);
    pulse_rsp();
    check("t2_busy_a", 32'(busy_o), 32'd3);
    pulse_rsp();
    check("t2_busy_b", 32'(busy_o), 32'd1);
    pulse_rsp();
    check("t2_busy_c", 32'(busy_o), 32'd0);
    check("t2_done0", done_of(0), 32'd3);
    check("t2_done1", done_of(1), 32'd1);
    stream_idx_i = 1'b0;
    #1;
    check("t2_next_id_s0", 32'(next_id_o), 32'd4);
    stream_idx_i = 1'b1;
    #1;
    check("t2_next_id_s1", 32'(next_id_o), 32'd2);

    // Completion with nothing outstanding.
    pulse_rsp();
    check("t3_done0", done_of(0), 32'd3);
    check("t3_done1", done_of(1), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_err", 32'(err_o), 32'(exp_err));

    // Fill to capacity; a same-cycle pop must not admit the ninth request.
    for (int i = 0; i < MO; i++) issue(1'b1, 4'(2 + i), 1'b0);
    check("t4_busy", 32'(busy_o), 32'd2);
    req_valid_i  = 1'b1;
    stream_idx_i = 1'b1;
    req_i        = 1'b0;
    #1;
    check("t4_full_ready", 32'(req_ready_o), 32'd0);
    check("t4_full_valid", 32'(req_valid_o), 32'd0);
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    check("t4_ready_after_pop", 32'(req_ready_o), 32'd1);
    check("t4_done1", done_of(1), 32'd2);
    exp_q.push_back(4'd10);
    tick();
    req_valid_i = 1'b0;
    check("t4_full_again", 32'(req_ready_o), 32'd0);

    // Simultaneous issue and retire on stream 1.
    pulse_rsp();
    check("t5_done1_a", done_of(1), 32'd3);
    issue(1'b1, 4'd11, 1'b1);
    check("t5_done1_b", done_of(1), 32'd4);
    check("t5_busy", 32'(busy_o), 32'd2);
    for (int i = 0; i < 7; i++) pulse_rsp();
    check("t5_done1_c", done_of(1), 32'd11);
    check("t5_busy_clr", 32'(busy_o), 32'd0);
    check("t5_ready", 32'(req_ready_o), 32'd1);
    check("t5_err_sticky", 32'(err_o), 32'(exp_err));

    // Fresh reset, then ID wrap on stream 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_err_clr", 32'(err_o), 32'd0);
    issue(1'b0, 4'd1, 1'b0);
    for (int i = 2; i < 16; i++) issue(1'b0, 4'(i), 1'b1);
    issue(1'b0, 4'd0, 1'b1);
    check("t6_done0", done_of(0), 32'd15);
    check("t6_busy", 32'(busy_o), 32'd1);
    stream_idx_i = 1'b0;
    #1;
    check("t6_next_after_wrap", 32'(next_id_o), 32'd1);
    issue(1'b0, 4'd1, 1'b0);
    issue(1'b0, 4'd2, 1'b0);

    // Asynchronous reset mid-burst, between clock edges.
    req_valid_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t7_busy", 32'(busy_o), 32'd0);
    check("t7_done0", done_of(0), 32'd0);
    check("t7_done1", done_of(1), 32'd0);
    check("t7_next_id", 32'(next_id_o), 32'd1);
    check("t7_req_valid_o", 32'(req_valid_o), 32'd0);
    check("t7_err", 32'(err_o), 32'd0);
    req_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("t7_busy_after", 32'(busy_o), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
